// File: rtl/ac_pkg.sv
// ---------------------------------------------------------------------------
// ac_pkg
// Shared types and default parameters for the multi-zone AC controller.
//   ac_state_t  : per-zone operating state (IDLE / HEAT / COOL)
//   AC_*_DEF    : default parameter values used by ac_zone_ctrl/ac_zone_fsm
//   dwell_bits  : width of a counter able to hold 0..MIN_DWELL
// ---------------------------------------------------------------------------
package ac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAT = 2'b01,
        COOL = 2'b10
    } ac_state_t;

    localparam int AC_WIDTH_DEF     = 5;
    localparam int AC_ZONES_DEF     = 4;
    localparam int AC_HYST_DEF      = 1;
    localparam int AC_MIN_DWELL_DEF = 4;

    function automatic int dwell_bits(input int min_dwell);
        return $clog2(min_dwell + 1);
    endfunction

endpackage

// File: rtl/ac_zone_fsm.sv
// ---------------------------------------------------------------------------
// ac_zone_fsm
// One zone's IDLE/HEAT/COOL controller with hysteresis and minimum dwell.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   temp_i          : zone temperature sample
//   valid_i         : sample strobe; decisions are only taken on valid cycles
//   sp_low_i        : heat-on threshold
//   sp_high_i       : cool-on threshold
//   force_idle_i    : registered config error, forces IDLE without dwell clear
//   heating_o       : registered heater enable
//   cooling_o       : registered cooler enable
//   heat_next_o     : next-state heater enable (for the registered aggregate OR)
//   cool_next_o     : next-state cooler enable
// ---------------------------------------------------------------------------
module ac_zone_fsm
    import ac_pkg::*;
#(
    parameter int WIDTH     = AC_WIDTH_DEF,
    parameter int HYST      = AC_HYST_DEF,
    parameter int MIN_DWELL = AC_MIN_DWELL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] temp_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] sp_low_i,
    input  logic [WIDTH-1:0] sp_high_i,
    input  logic             force_idle_i,
    output logic             heating_o,
    output logic             cooling_o,
    output logic             heat_next_o,
    output logic             cool_next_o
);

    localparam int               DW        = dwell_bits(MIN_DWELL);
    localparam logic [DW-1:0]    DWELL_MAX = DW'(MIN_DWELL);
    localparam logic [WIDTH:0]   HYST_W    = (WIDTH+1)'(HYST);

    ac_state_t      state_q, state_d;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic           heat_d, cool_d;
    logic           heating_q, cooling_q;

    // Thresholds are evaluated one bit wider so low+HYST cannot wrap and
    // high-HYST can be clamped at zero instead of underflowing.
    logic [WIDTH:0] temp_ext;
    logic [WIDTH:0] heat_exit_bound;
    logic [WIDTH:0] high_ext;
    logic [WIDTH:0] cool_exit_bound;
    logic           decide;

    assign temp_ext        = {1'b0, temp_i};
    assign heat_exit_bound = {1'b0, sp_low_i} + HYST_W;
    assign high_ext        = {1'b0, sp_high_i};
    assign cool_exit_bound = (high_ext >= HYST_W) ? (high_ext - HYST_W) : '0;
    assign decide          = valid_i && (dwell_q >= DWELL_MAX);

    // State register (also holds the registered outputs)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dwell_q   <= DWELL_MAX;
            heating_q <= 1'b0;
            cooling_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            heating_q <= heat_d;
            cooling_q <= cool_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (force_idle_i) begin
            state_d = IDLE;
        end else if (decide) begin
            case (state_q)
                IDLE: begin
                    if (temp_ext < {1'b0, sp_low_i})
                        state_d = HEAT;
                    else if (temp_ext > high_ext)
                        state_d = COOL;
                end
                HEAT: if (temp_ext >= heat_exit_bound) state_d = IDLE;
                COOL: if (temp_ext <= cool_exit_bound) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Dwell restarts at 1 on a real transition; a forced return to IDLE
    // keeps counting so the zone is not artificially held after the error.
    always_comb begin
        dwell_d = dwell_q;
        if ((state_d != state_q) && !force_idle_i)
            dwell_d = DW'(1);
        else if (dwell_q < DWELL_MAX)
            dwell_d = dwell_q + DW'(1);
    end

    // Output decode of the next state
    always_comb begin
        heat_d = (state_d == HEAT);
        cool_d = (state_d == COOL);
    end

    assign heating_o   = heating_q;
    assign cooling_o   = cooling_q;
    assign heat_next_o = heat_d;
    assign cool_next_o = cool_d;

endmodule

// File: rtl/ac_zone_ctrl.sv
// ---------------------------------------------------------------------------
// ac_zone_ctrl
// Multi-zone AC controller: ZONES independent zone FSMs sharing setpoints.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   temperature    : zone z sample at [z*WIDTH +: WIDTH]
//   temp_valid     : per-zone sample strobe
//   setpoint_low   : heat-on threshold (shared)
//   setpoint_high  : cool-on threshold (shared)
//   heating        : per-zone heater enable
//   cooling        : per-zone cooler enable
//   any_heat       : OR of heating
//   any_cool       : OR of cooling
//   cfg_err        : registered (setpoint_low > setpoint_high)
// ---------------------------------------------------------------------------
module ac_zone_ctrl
    import ac_pkg::*;
#(
    parameter int WIDTH     = AC_WIDTH_DEF,
    parameter int ZONES     = AC_ZONES_DEF,
    parameter int HYST      = AC_HYST_DEF,
    parameter int MIN_DWELL = AC_MIN_DWELL_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ZONES*WIDTH-1:0] temperature,
    input  logic [ZONES-1:0]       temp_valid,
    input  logic [WIDTH-1:0]       setpoint_low,
    input  logic [WIDTH-1:0]       setpoint_high,
    output logic [ZONES-1:0]       heating,
    output logic [ZONES-1:0]       cooling,
    output logic                   any_heat,
    output logic                   any_cool,
    output logic                   cfg_err
);

    logic             cfg_err_q, cfg_err_d;
    logic             any_heat_q, any_cool_q;
    logic [ZONES-1:0] heat_next, cool_next;

    assign cfg_err_d = (setpoint_low > setpoint_high);

    genvar gi;
    generate
        for (gi = 0; gi < ZONES; gi++) begin : g_zone
            ac_zone_fsm #(
                .WIDTH     (WIDTH),
                .HYST      (HYST),
                .MIN_DWELL (MIN_DWELL)
            ) u_zone (
                .clk          (clk),
                .rst_n        (rst_n),
                .temp_i       (temperature[gi*WIDTH +: WIDTH]),
                .valid_i      (temp_valid[gi]),
                .sp_low_i     (setpoint_low),
                .sp_high_i    (setpoint_high),
                .force_idle_i (cfg_err_q),
                .heating_o    (heating[gi]),
                .cooling_o    (cooling[gi]),
                .heat_next_o  (heat_next[gi]),
                .cool_next_o  (cool_next[gi])
            );
        end
    endgenerate

    // Aggregates are built from next-state values so they change on the
    // same edge as the per-zone outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q  <= 1'b0;
            any_heat_q <= 1'b0;
            any_cool_q <= 1'b0;
        end else begin
            cfg_err_q  <= cfg_err_d;
            any_heat_q <= |heat_next;
            any_cool_q <= |cool_next;
        end
    end

    assign cfg_err  = cfg_err_q;
    assign any_heat = any_heat_q;
    assign any_cool = any_cool_q;

endmodule

// File: doc/ac_zone_ctrl.md
# ac_zone_ctrl

Multi-zone air-conditioning controller: the parametrised successor to the single-zone AC block. Each of ZONES zones runs an independent IDLE/HEAT/COOL state machine driven by a WIDTH-bit temperature sample against shared runtime setpoints, with hysteresis and a minimum dwell time per state. The block sits between the temperature sensor front-end and the heater/cooler drivers. All outputs are registered.

## Interface
- WIDTH, 5: temperature and setpoint width, unsigned
- ZONES, 4: number of independent zones, at least 1
- HYST, 1: hysteresis band in temperature LSBs, 0 to 2^WIDTH-1
- MIN_DWELL, 4: minimum cycles held in any state before leaving it, at least 1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- temperature  in  ZONES*WIDTH  zone z sample at [z*WIDTH +: WIDTH]
- temp_valid  in  ZONES  per-zone sample strobe
- setpoint_low  in  WIDTH  heat-on threshold, shared by all zones
- setpoint_high  in  WIDTH  cool-on threshold, shared by all zones
- heating  out  ZONES  per-zone heater enable
- cooling  out  ZONES  per-zone cooler enable
- any_heat  out  1  OR of heating
- any_cool  out  1  OR of cooling
- cfg_err  out  1  setpoints invalid

## Operation
- Per-zone states: IDLE (heating=0, cooling=0), HEAT (1,0), COOL (0,1). heating and cooling are never both 1.
- The next-state decision is made only on cycles where temp_valid[z]=1 and dwell[z]>=MIN_DWELL. On all other cycles the state holds.
- IDLE to HEAT: T < setpoint_low. IDLE to COOL: T > setpoint_high. Otherwise the zone stays in IDLE.
- HEAT to IDLE: T >= setpoint_low + HYST. The sum is computed in WIDTH+1 bits, so there is no wrap.
- COOL to IDLE: T <= setpoint_high - HYST. If HYST > setpoint_high, the bound saturates at 0.
- HEAT and COOL never switch directly to each other. A zone must pass through IDLE and dwell there.
- dwell[z] is a saturating counter of ceil(log2(MIN_DWELL+1)) bits. It clears to 1 on every state change, increments by one each cycle otherwise, and saturates at MIN_DWELL.
- cfg_err is a registered flag equal to (setpoint_low > setpoint_high). Equal setpoints are legal.
- While cfg_err=1, every zone is forced to IDLE on each clock and dwell is not cleared by that forcing. cfg_err dominates temp_valid.
- any_heat and any_cool are registered ORs of the next-state heating and cooling, so they align with heating and cooling.

## Timing
- Reset (rst_n=0, asynchronous):
  - all zones go to IDLE with dwell=MIN_DWELL, so the first valid sample after reset can act immediately;
  - heating, cooling, any_heat, any_cool and cfg_err are all 0.
- Latency: a sample with temp_valid=1 at edge N drives heating and cooling from edge N. Outputs are visible in the cycle after the sample cycle.
- cfg_err latency: the setpoint condition registers at edge N and forces zones to IDLE from edge N+1.
- Reset asserted mid-operation returns every output to 0 immediately, without waiting for a clock. Release is synchronised externally.
- Zones are fully independent. Simultaneous valid samples across zones are all processed in the same cycle.

## Structure
- Shared package ac_pkg:
  - state enum ac_state_t with values IDLE=2'b00, HEAT=2'b01, COOL=2'b10;
  - default parameter constants.
- Sub-module ac_zone_fsm holds one zone's state register, dwell counter and threshold compares. It is instantiated ZONES times in a generate loop.
- The top level holds cfg_err, the aggregate ORs and the bus slicing.

## Test plan
All scenarios use WIDTH=5, ZONES=4, HYST=1, MIN_DWELL=4, low=18, high=22.
1. Reset, then zone0 T=17 with valid -> heating[0]=1 one cycle later, any_heat=1, other zones 0.
2. Zone0 in HEAT, T=18 -> stays HEAT. T=19 after at least 4 cycles in HEAT -> IDLE. T=19 only 2 cycles after entering HEAT -> stays HEAT until dwell reaches 4.
3. Zone1 T=23 -> COOL. Then T=10 -> IDLE first, and HEAT only after 4 more cycles with T=10 still valid. cooling and heating never overlap.
4. Zones 0-3 given T=17, 20, 23 and 17 in one cycle -> heating=4'b1001, cooling=4'b0100.
5. Set low=23, high=22 while zones are active -> cfg_err=1 next cycle and all outputs 0 the cycle after. Restore low=18 -> cfg_err clears and zones respond again.
6. Zone2 in COOL with HYST=25 and high=22 -> the exit bound saturates to 0, so zone2 leaves COOL only on T=0. Separately, asserting rst_n=0 mid-cycle -> outputs drop to 0 before the next edge.
